seg7_scan_driver: RTL

Four-digit multiplexed seven-segment driver that sits directly downstream of the signed ALU's BCD converter. It captures the sign flag and the hundreds/tens/ones BCD digits and time-multiplexes them onto a common-anode display: a minus sign, then three decimal digits. Display updates happen only at frame boundaries, so the display never tears. A ghost-suppression guard interval separates successive digits.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and active-low segment encodings ({g,f,e,d,c,b,a}) for the
// seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        StGuard,
        StShow
    } scan_state_t;

    typedef struct packed {
        logic       sign;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } disp_val_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show "E".
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode driver: sign + three BCD digits, frame-synchronous update.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on the hundreds and tens digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       sign_in,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    scan_state_t      state_q, state_d;
    disp_val_t        pend_q, pend_d, shadow_q, shadow_d, in_val;
    logic [3:0]       an_d;
    logic [6:0]       seg_d, dig_seg;
    logic             frame_d, slot_end, frame_end;
    logic [3:0]       bcd_sel;
    logic             blank_sel, blank_h, blank_t;

    assign in_val    = '{sign: sign_in, hundreds: hundreds, tens: tens, ones: ones};
    assign slot_end  = (cnt_q == CNT_MAX);
    assign frame_end = slot_end && (idx_q == 2'd0);

    // Next-state: counters, capture registers and scan FSM.
    always_comb begin
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q - 1'b1 : idx_q;
        pend_d   = load ? in_val : pend_q;
        // pend_d already carries a coincident load, so it lands at this boundary.
        shadow_d = frame_end ? pend_d : shadow_q;
        state_d  = state_q;
        unique case (state_q)
            StGuard: if (cnt_q == GUARD_LAST) state_d = StShow;
            StShow:  if (slot_end) state_d = StGuard;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_h = (shadow_d.hundreds == 4'd0);
    assign blank_t = blank_h && (shadow_d.tens == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    bcd_to_seg7 u_dec (
        .bcd (bcd_sel),
        .seg (dig_seg)
    );

    // Outputs are decoded from next-state so the registered pins line up with the slot counter.
    always_comb begin
        bcd_sel   = shadow_d.ones;
        blank_sel = 1'b0;
        unique case (idx_d)
            2'd2: begin
                bcd_sel   = shadow_d.hundreds;
                blank_sel = blank_h;
            end
            2'd1: begin
                bcd_sel   = shadow_d.tens;
                blank_sel = blank_t;
            end
            default: ;
        endcase

        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        if (state_d == StShow) begin
            an_d = ~(4'b0001 << idx_d);
            if (idx_d == 2'd3) begin
                seg_d = shadow_d.sign ? SEG_MINUS : SEG_BLANK;
            end else if (!blank_sel) begin
                seg_d = dig_seg;
            end
        end
        frame_d = (idx_d == 2'd0) && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd3;
            state_q  <= StGuard;
            pend_q   <= '0;
            shadow_q <= '0;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
            frame    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            an       <= an_d;
            seg      <= seg_d;
            frame    <= frame_d;
        end
    end

    assign dp = 1'b1;

endmodule
